nco_meas: RTL and testbench
===========================

NCO_MEAS -- requirements
Module: nco_meas

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 32, giving the width of the period counter and of num.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  measurement enable; high = measure, low = hold idle.
REQ-005 sig_in  input  1  asynchronous square-wave input, e.g. a divided clock; its period is measured in clk cycles.
REQ-006 num  output  CNT_W  last measured period in clk cycles, rising edge to rising edge.
REQ-007 num_vld  output  1  single-cycle strobe; high in the cycle num/ovf update.
REQ-008 ovf  output  1  the period reported with the current num saturated.
REQ-009 busy  output  1  high while in state MEASURE.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer (s1, s2); a rising edge SHALL be detected as s2 & ~s2_d, where s2_d is s2 delayed one cycle.
REQ-011 FSM states SHALL be IDLE and MEASURE; reset state SHALL be IDLE.
REQ-012 IDLE: cnt held at 0; on a detected edge with en=1, go to MEASURE and set cnt to 1; no num_vld.
REQ-013 MEASURE, no edge: cnt SHALL increment by 1 per clk and saturate at all-ones (2^CNT_W-1), never wrapping.
REQ-014 MEASURE, on a detected edge: num <= cnt; ovf <= (cnt == all-ones); num_vld <= 1 for exactly one cycle; cnt <= 1; stay in MEASURE.
REQ-015 For edges detected at cycles E1 and E2, the reported num SHALL equal E2-E1.
REQ-016 num_vld SHALL rise at the 3rd clk rising edge, counting the first edge that samples sig_in high as edge 1. The optional filter in REQ-023 adds 2 more cycles.
REQ-017 en=0 in any state: next state SHALL be IDLE, cnt SHALL be 0 and num_vld SHALL be 0; num and ovf SHALL hold their values. An edge in the same cycle as en=0 SHALL be ignored.
REQ-018 Re-asserting en SHALL discard the partial period; the first edge after re-enable only starts a new measurement.
REQ-019 num and ovf SHALL change only in cycles where num_vld=1.
REQ-020 busy SHALL be registered state, asserted exactly while the FSM is in MEASURE.

Reset
REQ-021 While rst_n=0: state=IDLE, cnt=0, s1=s2=s2_d=0, num=0, num_vld=0, ovf=0, busy=0.
REQ-022 Reset asserted mid-measurement SHALL abort it with no num_vld. After release, the first edge only starts a new measurement.

Configuration
REQ-023 Macro NCO_MEAS_FILTER_EN, when defined, SHALL insert a glitch filter after s2.
- The filtered level changes only after s2 holds a new value for 3 consecutive clk samples.
- Edge detection uses the filtered level.
- Latency increases by 2 cycles.
- Pulses shorter than 3 cycles, high or low, are rejected.
- Steady-state period results are unchanged.
REQ-024 Without NCO_MEAS_FILTER_EN, edge detection SHALL use s2 directly with the REQ-016 latency. No filter logic SHALL be present.

Verification
REQ-025 en=1, sig_in period 10 clk, 50% duty -> first num_vld after the 2nd sig_in rise, num=10, ovf=0; repeats every 10 clk.
REQ-026 Periods 7 then 23 then 7 -> successive num=7, 23, 7, each with a one-cycle num_vld.
REQ-027 CNT_W=8, period 300 clk -> num=255, ovf=1. Then period 50 -> num=50, ovf=0.
REQ-028 en dropped for 5 cycles mid-period -> no num_vld, busy=0, num holds. After re-enable, the first rise gives no result and the second rise reports the correct period.
REQ-029 rst_n pulsed low mid-period -> all outputs 0 immediately (asynchronous), no strobe. Measurement resumes correctly after two rises.
REQ-030 NCO_MEAS_FILTER_EN defined, 1-cycle glitch inside a period-20 wave -> num stays 20, no extra num_vld. Without the macro, the glitch produces a short-period result.

Source files
------------

// File: rtl/nco_meas.sv
// Measures the period of an asynchronous square wave in clk cycles, rising edge to rising edge.
// Optional glitch filter on the synchronized input: define NCO_MEAS_FILTER_EN.
//
// state   | meaning
// IDLE    | not measuring; waiting for the first rising edge with en=1
// MEASURE | counting clk cycles since the last rising edge
module nco_meas #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] num,
  output logic             num_vld,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cap;
  logic             s1;
  logic             s2;
  logic             s2_d;
  logic             rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      s2_d <= s2;
    end
  end

`ifdef NCO_MEAS_FILTER_EN
  // Level only follows s2 once the last three s2 samples agree; combinational
  // output keeps the added latency at two cycles.
  logic s2_dd;
  logic filt_q;
  logic filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_dd  <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s2_dd  <= s2_d;
      filt_q <= filt;
    end
  end

  always_comb begin
    filt = filt_q;
    if ((s2 == s2_d) && (s2_d == s2_dd)) filt = s2;
  end

  assign rise = filt & ~filt_q;
`else
  assign rise = s2 & ~s2_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_nxt = MEASURE;
        MEASURE: state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    cap     = 1'b0;
    if (!en) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: cnt_nxt = rise ? CNT_ONE : '0;
        MEASURE: begin
          if (rise) begin
            cap     = 1'b1;
            cnt_nxt = CNT_ONE;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      num     <= '0;
      ovf     <= 1'b0;
      num_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      num_vld <= cap;
      busy    <= (state_nxt == MEASURE);
      if (cap) begin
        num <= cnt;
        ovf <= (cnt == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_nco_meas.sv
// Self-checking bench for nco_meas: directed and random waveforms against a
// per-cycle level/edge reference model (filtered when NCO_MEAS_FILTER_EN is defined).
module tb_nco_meas;

  localparam int W   = 8;
  localparam int MAX = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sig_in;
  logic [W-1:0] num;
  logic         num_vld;
  logic         ovf;
  logic         busy;

  always #5 clk = ~clk;

  nco_meas #(.CNT_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sig_in  (sig_in),
    .num     (num),
    .num_vld (num_vld),
    .ovf     (ovf),
    .busy    (busy)
  );

  typedef struct {
    int at;
    int num;
    bit ovf;
  } res_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  res_t exp_q[$];
  bit   m_p1, m_p2, m_f;
  bit   armed;
  int   last_rise;
  int   busy_on;
  int   exp_num;
  bit   exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
  endtask

  task automatic check_cycle();
    bit vld_exp;
    vld_exp = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      vld_exp = 1'b1;
      exp_num = exp_q[0].num;
      exp_ovf = exp_q[0].ovf;
      void'(exp_q.pop_front());
    end
    chk("num_vld", 32'(num_vld), 32'(vld_exp));
    chk("num", 32'(num), 32'(exp_num));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("busy", 32'(busy), 32'(armed && (cyc >= busy_on)));
  endtask

  // Reference: rises of the sampled level (optionally 3-sample filtered); a result
  // appears 3 cycles after a rise that follows an earlier enabled rise.
  task automatic model_sample(input bit lvl);
    bit   rise;
    int   d;
    res_t r;
`ifdef NCO_MEAS_FILTER_EN
    bit nf;
    nf   = (lvl == m_p1 && m_p1 == m_p2) ? lvl : m_f;
    rise = nf && !m_f;
    m_f  = nf;
`else
    rise = lvl && !m_p1;
`endif
    m_p2 = m_p1;
    m_p1 = lvl;
    if (!en) begin
      armed = 1'b0;
    end else if (rise) begin
      if (armed) begin
        d     = cyc - last_rise;
        r.at  = cyc + 3;
        r.num = (d > MAX) ? MAX : d;
        r.ovf = (d >= MAX);
        exp_q.push_back(r);
      end else begin
        armed   = 1'b1;
        busy_on = cyc + 3;
      end
      last_rise = cyc;
    end
  endtask

  task automatic step(input bit lvl, input bit e);
    @(negedge clk);
    check_cycle();
    en     = e;
    sig_in = lvl;
    model_sample(lvl);
    cyc++;
  endtask

  task automatic wave(input int p, input int h);
    for (int i = 0; i < h; i++) step(1'b1, 1'b1);
    for (int i = 0; i < p - h; i++) step(1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check_cycle();
    cyc++;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_vld", 32'(num_vld), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    armed   = 1'b0;
    m_p1    = 1'b0;
    m_p2    = 1'b0;
    m_f     = 1'b0;
    exp_num = 0;
    exp_ovf = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int p;
    int h;
    rst_n     = 1'b0;
    en        = 1'b0;
    sig_in    = 1'b0;
    armed     = 1'b0;
    m_p1      = 1'b0;
    m_p2      = 1'b0;
    m_f       = 1'b0;
    last_rise = 0;
    busy_on   = 0;
    exp_num   = 0;
    exp_ovf   = 1'b0;
    #1;
    chk("init_num", 32'(num), 32'd0);
    chk("init_vld", 32'(num_vld), 32'd0);
    chk("init_ovf", 32'(ovf), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    repeat (4) wave(10, 5);

    wave(7, 3);
    wave(23, 11);
    wave(7, 4);
    wave(10, 5);

    wave(300, 150);
    wave(50, 25);
    wave(255, 100);
    wave(254, 100);
    wave(20, 10);

    // enable dropped for 5 cycles in the low phase of a period
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    wave(30, 10);
    wave(12, 6);
    wave(10, 5);

    // reset in the middle of a period
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    pulse_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
    wave(18, 9);
    wave(18, 9);
    wave(10, 5);

    // one-cycle glitches inside a period-20 wave
    repeat (3) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    wave(20, 10);

    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(60, 6));
      h = int'($urandom_range(p - 3, 3));
      wave(p, h);
    end

    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("pending_results", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
